mips_div: RTL and testbench

Iterative radix-2 restoring divider for the MIPS DIV/DIVU instructions. It sits in the EX stage beside the ALU. It produces the pipeline stall that gates the enable inputs of the enabled/resettable pipeline registers, and it delivers the `{HI, LO}` pair that the EX/MEM register captures when the stall drops.

---
 rtl/mips_div_pkg.sv | 13 +
 rtl/div_sign_fix.sv | 18 +
 rtl/mips_div.sv | 157 +++++++++++++++
 tb/tb_mips_div.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU divider.
package mips_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of a pair of values.
// Used for operand magnitudes on the way in and for the quotient and
// remainder sign fix-up on the way out.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             neg_hi_i,
    input  logic             neg_lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    assign hi_o = neg_hi_i ? -hi_i : hi_i;
    assign lo_o = neg_lo_i ? -lo_i : lo_i;

endmodule

// File: rtl/mips_div.sv
// Radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
// Produces the EX-stage stall and the registered {HI, LO} result.
// Optional feature: define MIPS_DIV_ZERO_FAST_EN to finish a divide by zero
// in one cycle instead of running all WIDTH iterations.
module mips_div
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               cancel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               div_stall
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef MIPS_DIV_ZERO_FAST_EN
    localparam bit ZERO_FAST = 1'b1;
`else
    localparam bit ZERO_FAST = 1'b0;
`endif

    div_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   prem_q, prem_d;   // partial remainder (kept value always < divisor)
    logic [WIDTH-1:0]   quo_q, quo_d;     // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               sa, sb, b_zero, accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   prem_nx, quo_nx;
    logic [WIDTH-1:0]   fix_rem, fix_quo;

    // Operand signs only matter for DIV; DIVU treats both as magnitudes.
    assign sa     = signed_div & a[WIDTH-1];
    assign sb     = signed_div & b[WIDTH-1];
    assign b_zero = (b == '0);
    assign accept = (state_q == S_IDLE) & start & ~cancel;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs (
        .hi_i     (a),
        .lo_i     (b),
        .neg_hi_i (sa),
        .neg_lo_i (sb),
        .hi_o     (abs_a),
        .lo_o     (abs_b)
    );

    // One restoring step on a WIDTH+1 bit window: a set MSB in the
    // difference means the trial subtract went negative.
    assign shifted = {prem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr_q};
    assign prem_nx = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

    div_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .hi_i     (prem_nx),
        .lo_i     (quo_nx),
        .neg_hi_i (rneg_q),
        .neg_lo_i (qneg_q),
        .hi_o     (fix_rem),
        .lo_o     (fix_quo)
    );

    // FSM next state; cancel always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (ZERO_FAST && b_zero) ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (cancel)              state_d = S_IDLE;
                else if (cnt_q == LAST)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next state: latch operands on accept, iterate in BUSY,
    // load the sign-corrected result on the final iteration.
    always_comb begin
        cnt_d    = cnt_q;
        prem_d   = prem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d  = '0;
                    prem_d = '0;
                    quo_d  = abs_a;
                    dvsr_d = abs_b;
                    qneg_d = sa ^ sb;
                    rneg_d = sa;
                    if (ZERO_FAST && b_zero)
                        result_d = {a, sa ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}}};
                end
            end
            S_BUSY: begin
                if (!cancel) begin
                    cnt_d  = cnt_q + 1'b1;
                    prem_d = prem_nx;
                    quo_d  = quo_nx;
                    if (cnt_q == LAST) result_d = {fix_rem, fix_quo};
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prem_q   <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prem_q   <= prem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    // Outputs: stall from the first start cycle through BUSY; ready only in
    // DONE and only if no flush arrives that cycle.
    always_comb begin
        div_stall = accept | (state_q == S_BUSY);
        ready     = (state_q == S_DONE) & ~cancel;
        result    = result_q;
    end

endmodule

// File: tb/tb_mips_div.sv
// Self-checking bench for mips_div: directed table, flush/reset sequences,
// and randomized divides against an arithmetic reference.
module tb_mips_div;

    logic        clk = 1'b0;
    logic        rst, start, signed_div, cancel;
    logic [31:0] a, b;
    logic [63:0] result;
    logic        ready, div_stall;

    int total = 0;
    int bad   = 0;

`ifdef MIPS_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    mips_div dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .result     (result),
        .ready      (ready),
        .div_stall  (div_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division with the MIPS corner cases.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy, q, r;
        if (!s) begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
        end
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sy == 0) return {x, (sx < 0) ? 32'd1 : 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide, hold start through DONE, return result and latency.
    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                           output logic [63:0] res, output int lat);
        bit stall_ok = 1'b1;
        bit got = 1'b0;
        int exp_lat = (FAST && y == 0) ? 1 : 33;
        step();
        a = x; b = y; signed_div = s; start = 1'b1;
        lat = -1;
        res = '0;
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                got = 1'b1;
                res = result;
                chk("stall_in_done", 64'(div_stall), 64'(0));
                break;
            end
            if (!div_stall) stall_ok = 1'b0;
            step();
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got none want ready within 60 cycles");
        end
        chk("stall_until_done", 64'(stall_ok), 64'(1));
        chk("latency", 64'(lat), 64'(exp_lat));
        step();
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {62'd0, ready, div_stall}, 64'd0);
    endtask

    logic [63:0] res, prev;
    int          lat;
    bit          no_rdy;

    initial begin
        tbl[0]  = '{32'd100,        32'd7,          1'b0, {32'h0000_0002, 32'h0000_000E}};
        tbl[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        tbl[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}};
        tbl[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0000_0000, 32'h8000_0000}};
        tbl[4]  = '{32'h0000_1234,  32'd0,          1'b0, {32'h0000_1234, 32'hFFFF_FFFF}};
        tbl[5]  = '{32'hFFFF_FFF6,  32'd0,          1'b1, {32'hFFFF_FFF6, 32'h0000_0001}};
        tbl[6]  = '{32'h0000_1234,  32'd0,          1'b1, {32'h0000_1234, 32'hFFFF_FFFF}};
        tbl[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'h0000_0000}};
        tbl[8]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0000_0000, 32'hFFFF_FFFF}};
        tbl[9]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, {32'hFFFF_FFFF, 32'h0000_0003}};
        tbl[10] = '{32'd5,          32'd9,          1'b0, {32'h0000_0005, 32'h0000_0000}};

        rst = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        repeat (2) step();
        @(negedge clk);
        chk("reset_outputs", {result[61:0], ready, div_stall}, 64'd0);
        chk("reset_result_hi", {62'd0, result[63:62]}, 64'd0);
        step();
        rst = 1'b1;

        // Directed table.
        foreach (tbl[i]) begin
            run_div(tbl[i].a, tbl[i].b, tbl[i].s, res, lat);
            chk($sformatf("table_%0d", i), res, tbl[i].exp);
        end
        prev = res;

        // Flush in cycle 10: IDLE in 11 with no ready, result untouched.
        step();
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        no_rdy = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (ready) no_rdy = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        if (ready) no_rdy = 1'b0;
        step();
        cancel = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("cancel_no_ready", 64'(no_rdy & ~ready), 64'(1));
        chk("cancel_stall_drop", 64'(div_stall), 64'(0));
        chk("cancel_result_kept", result, prev);
        run_div(32'd1000, 32'd3, 1'b0, res, lat);
        chk("after_cancel", res, {32'd1, 32'd333});

        // Flush in IDLE beats start.
        step();
        a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        chk("cancel_blocks_start", 64'(div_stall), 64'(0));
        step();
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("cancel_idle_stays", {62'd0, ready, div_stall}, 64'd0);

        // Flush in DONE suppresses the ready pulse.
        step();
        a = 32'd77; b = 32'd10; signed_div = 1'b0; start = 1'b1;
        for (int c = 1; c <= 33; c++) step();
        cancel = 1'b1;
        @(negedge clk);
        chk("cancel_done_ready", 64'(ready), 64'(0));
        step();
        cancel = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("cancel_done_idle", {62'd0, ready, div_stall}, 64'd0);

        // Reset in cycle 5 of a divide clears everything.
        step();
        a = 32'd50; b = 32'd5; start = 1'b1;
        for (int c = 1; c <= 5; c++) step();
        rst = 1'b0; start = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_div", {result[61:0], ready, div_stall}, 64'd0);
        chk("rst_mid_div_hi", {62'd0, result[63:62]}, 64'd0);
        step();
        @(negedge clk);
        chk("rst_no_resume", {62'd0, ready, div_stall}, 64'd0);

        // Randomized divides against the reference.
        for (int n = 0; n < 30; n++) begin
            logic [31:0] x, y;
            logic        s;
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = $urandom;
                1: y = $urandom_range(1, 20);
                2: y = 32'd0;
                default: y = -$urandom_range(1, 20);
            endcase
            s = 1'($urandom_range(0, 1));
            run_div(x, y, s, res, lat);
            chk($sformatf("rand_%0d", n), res, ref_div(x, y, s));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
